// File: rtl/types.sv
// Shared half-float vector and triangle types for the triangle-normal path.
package types;
  typedef logic [15:0] f16;
  typedef struct packed { f16 x; f16 y; f16 z; } vec3_f16;
  typedef struct packed { vec3_f16 p1; vec3_f16 p2; vec3_f16 p3; } tri_3d;
endpackage

// File: rtl/triangle_normal_sched.sv
// Issue/completion controller for the triangle-normal datapath: credit-gated issue, tag pairing,
// in-order result buffering. Optional zero-normal flag via `TN_SCHED_DEGEN_EN.
module triangle_normal_sched
  import types::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  tri_3d            in_triangle,
  input  logic [TAG_W-1:0] in_tag,
  output logic             tn_input_valid,
  output tri_3d            tn_triangle,
  input  vec3_f16          tn_normal,
  input  logic             tn_normal_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output vec3_f16          out_normal,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_degenerate,
  output logic             busy,
  output logic             err
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [CW-1:0]    r_pending;
  logic [CW-1:0]    r_tag_wr, r_tag_rd, r_out_wr, r_out_rd;
  logic             r_err;
  logic             r_tn_valid;
  tri_3d            r_tn_tri;
  logic [TAG_W-1:0] r_tag_mem  [DEPTH];
  logic [TAG_W-1:0] r_otag_mem [DEPTH];
  vec3_f16          r_onorm_mem[DEPTH];

  logic w_accept, w_out_pop, w_tag_empty, w_out_empty, w_cpl, w_spurious;

  assign in_ready    = !rst && (r_pending < DepthC);
  assign w_accept    = in_valid && in_ready;
  assign w_tag_empty = (r_tag_wr == r_tag_rd);
  assign w_out_empty = (r_out_wr == r_out_rd);
  assign out_valid   = !w_out_empty;
  assign w_out_pop   = out_valid && out_ready;
  assign w_cpl       = tn_normal_valid && !w_tag_empty;
  assign w_spurious  = tn_normal_valid && w_tag_empty;

  assign tn_input_valid = r_tn_valid;
  assign tn_triangle    = r_tn_tri;
  assign out_tag        = r_otag_mem[r_out_rd[AW-1:0]];
  assign out_normal     = r_onorm_mem[r_out_rd[AW-1:0]];
  assign busy           = (r_pending != '0);
  assign err            = r_err;

  // Credits cover both FIFOs, so neither push below needs a full check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending  <= '0;
      r_err      <= 1'b0;
      r_tn_valid <= 1'b0;
      r_tn_tri   <= '0;
    end else begin
      unique case ({w_accept, w_out_pop})
        2'b10:   r_pending <= r_pending + CW'(1);
        2'b01:   r_pending <= r_pending - CW'(1);
        default: r_pending <= r_pending;
      endcase
      if (w_spurious) r_err <= 1'b1;
      r_tn_valid <= w_accept;
      if (w_accept) r_tn_tri <= in_triangle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_wr <= '0;
      r_tag_rd <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_tag_mem[i] <= '0;
    end else begin
      if (w_accept) begin
        r_tag_mem[r_tag_wr[AW-1:0]] <= in_tag;
        r_tag_wr <= r_tag_wr + CW'(1);
      end
      if (w_cpl) r_tag_rd <= r_tag_rd + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_wr <= '0;
      r_out_rd <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_otag_mem[i]  <= '0;
        r_onorm_mem[i] <= '0;
      end
    end else begin
      if (w_cpl) begin
        r_otag_mem[r_out_wr[AW-1:0]]  <= r_tag_mem[r_tag_rd[AW-1:0]];
        r_onorm_mem[r_out_wr[AW-1:0]] <= tn_normal;
        r_out_wr <= r_out_wr + CW'(1);
      end
      if (w_out_pop) r_out_rd <= r_out_rd + CW'(1);
    end
  end

`ifdef TN_SCHED_DEGEN_EN
  logic r_odeg_mem [DEPTH];
  logic w_degen;

  // Sign bit ignored so -0.0 also counts as zero.
  assign w_degen = (tn_normal.x[14:0] == 15'd0) && (tn_normal.y[14:0] == 15'd0) &&
                   (tn_normal.z[14:0] == 15'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_odeg_mem[i] <= 1'b0;
    end else if (w_cpl) begin
      r_odeg_mem[r_out_wr[AW-1:0]] <= w_degen;
    end
  end

  assign out_degenerate = r_odeg_mem[r_out_rd[AW-1:0]];
`else
  assign out_degenerate = 1'b0;
`endif

endmodule

// File: doc/triangle_normal_sched.md
# triangle_normal_sched

Issue and completion controller for the pipelined triangle-normal datapath (two vertex subtractors feeding three multiply-subtract units, fixed but unspecified latency, valid-only, no backpressure). It accepts tagged triangles over a valid/ready stream and issues them to the datapath. It pairs each in-order result with its tag and buffers results so that a stalled consumer never causes a dropped normal. It sits between the rasterizer's triangle fetch and the shading stage, and uses the `types` package (`f16`, `vec3_f16`, `tri_3d`).

## Interface
- `DEPTH`, 8: maximum triangles in flight plus buffered; power of two, ≥2
- `TAG_W`, 8: width of the caller-supplied triangle tag
- `clk` in 1: system clock, all logic on rising edge
- `rst` in 1: **reset is asynchronous and active-high**; single clock domain
- `in_valid` in 1: triangle offered
- `in_ready` out 1: triangle accepted when `in_valid && in_ready`
- `in_triangle` in `tri_3d`: vertices p1, p2, p3
- `in_tag` in `TAG_W`: tag returned with the normal
- `tn_input_valid` out 1: issue strobe to datapath `input_valid`
- `tn_triangle` out `tri_3d`: datapath `triangle`, registered
- `tn_normal` in `vec3_f16`: datapath `normal`
- `tn_normal_valid` in 1: datapath `normal_valid`
- `out_valid` out 1: result available
- `out_ready` in 1: consumer takes result when `out_valid && out_ready`
- `out_normal` out `vec3_f16`: cross product (p2−p1)×(p3−p1)
- `out_tag` out `TAG_W`: tag of the triangle that produced `out_normal`
- `out_degenerate` out 1: zero-normal flag (see Configuration)
- `busy` out 1: `pending != 0`
- `err` out 1: sticky; completion arrived with no outstanding tag

## Operation
- `pending` counter, width $clog2(DEPTH)+1: +1 on input accept, −1 on output handshake; both in one cycle → unchanged.
- `in_ready = !rst && (pending < DEPTH)`, combinational from registered `pending`. The credit scheme guarantees tag-FIFO and output-FIFO space, so no datapath result is ever lost.
- On accept: push `in_tag` into tag FIFO (depth DEPTH); register `tn_triangle <= in_triangle`, `tn_input_valid <= 1`. Otherwise `tn_input_valid <= 0` and `tn_triangle` holds.
- On `tn_normal_valid`: pop tag FIFO head; write {tag, `tn_normal`, degenerate} into output FIFO (depth DEPTH, show-ahead).
- `tn_normal_valid` with tag FIFO empty: set `err`, discard the result, leave `pending` unchanged. `err` clears only on `rst`.
- Output: `out_valid = !out_fifo_empty`; `out_*` fields are driven from the FIFO head and held stable while `out_valid && !out_ready`.
- Results leave strictly in issue order; the datapath is in-order.
- Pointers wrap modulo DEPTH; full/empty are tracked by an extra pointer bit.

## Timing
- Reset values: `tn_input_valid`=0, `tn_triangle`=0, `out_valid`=0, `out_*` data=0, `busy`=0, `err`=0, `pending`=0, all FIFOs empty. `in_ready`=0 while `rst` is high and 1 in the first cycle after release.
- Issue latency: accept at edge N → `tn_input_valid` high in cycle N+1, for exactly one cycle per triangle. Back-to-back accepts give a one-per-cycle issue.
- Completion latency: `tn_normal_valid` at edge M → `out_valid` visible in cycle M+1 (registered write).
- Credit return: an output handshake at edge K raises `in_ready` in cycle K+1 when `pending` was DEPTH.
- Reset mid-operation clears all state immediately. The datapath shares `rst`, so in-flight results are flushed with it.

## Configuration
- `TN_SCHED_DEGEN_EN` defined: `out_degenerate` = 1 iff all three `tn_normal` components have exponent and mantissa zero (±0.0). The flag is computed at FIFO write and stored per entry, which widens the FIFO by 1 bit.
- Not defined: no storage and no compare logic; `out_degenerate` is tied to 0.

## Test plan
- Single triangle: p1=(0,0,0), p2=(1,0,0) (`3C00`), p3=(0,1,0), tag `05`; bench datapath returns {0000,0000,3C00} after 7 cycles. Required: `tn_input_valid` one cycle after accept; `out_valid` one cycle after completion with `out_normal`={0000,0000,3C00} and `out_tag`=`05`; `busy` drops after the output handshake.
- Fill/backpressure, DEPTH=8, `out_ready`=0: 8 accepts, then `in_ready`=0 and the 9th is held. Pulse `out_ready` once → `in_ready`=1 the next cycle and the 9th is accepted.
- Ordering: tags 1,2,3,4 back to back, completions spaced 3 cycles apart, `out_ready` toggling → outputs carry tags 1,2,3,4 in order with data unchanged across stalls.
- Simultaneous accept and output pop at `pending`=3 → `pending` stays 3 and `in_ready` stays 1.
- Spurious `tn_normal_valid` after reset with no accepts → `err`=1 and stays 1; `out_valid` stays 0. Assert `rst` → `err`=0.
- With `TN_SCHED_DEGEN_EN`: completion {0000,8000,0000} → `out_degenerate`=1; completion {3C00,0000,0000} → 0. Without the macro, both → 0.
